// File: rtl/bcd_display_pkg.sv
// ============================================================================
// bcd_display_pkg : shared state encoding and segment constants
// Rev 1.0
// ============================================================================
`default_nettype none

package bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_e;

  // Active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000, 7'b001_1001,
    7'b001_0010, 7'b000_0010, 7'b111_1000, 7'b000_0000, 7'b001_1000
  };
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  localparam logic [6:0] SEG_DASH  = 7'b011_1111;

endpackage

`default_nettype wire

// File: rtl/seven_seg_bcd.sv
// ============================================================================
// seven_seg_bcd : combinational BCD digit to active-low seven-segment decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module seven_seg_bcd
  import bcd_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Non-decimal codes cannot occur after a valid conversion; show a dash.
  always_comb begin
    seg_o = SEG_DASH;
    if (bcd_i <= 4'd9) seg_o = SEG_DIGIT[bcd_i];
  end

endmodule

`default_nettype wire

// File: rtl/bcd_display_seq.sv
// ============================================================================
// bcd_display_seq : handshaked binary to NDIGITS seven-segment display driver
//                   using an iterative double-dabble engine
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_display_seq
  import bcd_display_pkg::*;
#(
  parameter int WIDTH   = 5,
  parameter int NDIGITS = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [WIDTH-1:0]       in,
  input  logic                   blank_lz,
  output logic [7*NDIGITS-1:0]   seg,
  output logic                   ovf,
  output logic                   done
);

  localparam int             BW   = 4 * NDIGITS;
  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic                 acc_q, acc_d;
  logic [7*NDIGITS-1:0] seg_q, seg_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  logic [BW-1:0]        w_adj;
  logic [6:0]           w_dig_seg [NDIGITS];
  logic [7*NDIGITS-1:0] w_disp;
  logic                 w_lead;

  for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
    seven_seg_bcd u_dec (
      .bcd_i (bcd_q[4*g +: 4]),
      .seg_o (w_dig_seg[g])
    );
  end

  always_comb begin
    w_adj = bcd_q;
    for (int k = 0; k < NDIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Scan from the top digit; blanking stops at the first nonzero digit.
  always_comb begin
    w_lead = 1'b1;
    w_disp = '0;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      if (acc_q) begin
        w_disp[7*k +: 7] = SEG_DASH;
      end else if (mode_q && w_lead && (k != 0) && (bcd_q[4*k +: 4] == 4'd0)) begin
        w_disp[7*k +: 7] = SEG_BLANK;
      end else begin
        w_disp[7*k +: 7] = w_dig_seg[k];
        w_lead           = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    seg_d   = seg_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_val) begin
          shift_d = in;
          mode_d  = blank_lz;
          bcd_d   = '0;
          cnt_d   = '0;
          acc_d   = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d   = {w_adj[BW-2:0], shift_q[WIDTH-1]};
        shift_d = shift_q << 1;
        acc_d   = acc_q | w_adj[BW-1];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = LOAD;
      end
      LOAD: begin
        seg_d   = w_disp;
        ovf_d   = acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      acc_q   <= 1'b0;
      seg_q   <= {NDIGITS{SEG_DIGIT[0]}};
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      seg_q   <= seg_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign in_rdy = (state_q == IDLE);
  assign seg    = seg_q;
  assign ovf    = ovf_q;
  assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_seq.sv
// ============================================================================
// tb_bcd_display_seq : directed self-checking bench, WIDTH=5 and WIDTH=8 DUTs
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bcd_display_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_val5, rdy5, blz5, ovf5, done5;
  logic [4:0]  in5;
  logic [13:0] seg5;
  logic        in_val8, rdy8, blz8, ovf8, done8;
  logic [7:0]  in8;
  logic [13:0] seg8;

  int n_tests = 0;
  int n_fail  = 0;
  int busy, dones;
  bit seen;

  localparam logic [13:0] S00 = 14'b100_0000_100_0000;

  always #5 clk = ~clk;

  bcd_display_seq #(.WIDTH(5), .NDIGITS(2)) u_dut5 (
    .clk(clk), .reset_n(rst_n), .in_val(in_val5), .in_rdy(rdy5), .in(in5),
    .blank_lz(blz5), .seg(seg5), .ovf(ovf5), .done(done5)
  );

  bcd_display_seq #(.WIDTH(8), .NDIGITS(2)) u_dut8 (
    .clk(clk), .reset_n(rst_n), .in_val(in_val8), .in_rdy(rdy8), .in(in8),
    .blank_lz(blz8), .seg(seg8), .ovf(ovf8), .done(done8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One handshake, then observe 14 cycles counting busy cycles and done pulses.
  task automatic convert(input bit w8, input logic [7:0] v, input logic blz,
                         output int nbusy, output int ndone);
    @(negedge clk);
    if (w8) begin in_val8 = 1'b1; in8 = v; blz8 = blz; end
    else    begin in_val5 = 1'b1; in5 = v[4:0]; blz5 = blz; end
    @(negedge clk);
    in_val5 = 1'b0; in_val8 = 1'b0;
    in5 = ~in5; in8 = ~in8; blz5 = ~blz5; blz8 = ~blz8;
    nbusy = 0; ndone = 0;
    for (int i = 0; i < 14; i++) begin
      if (!(w8 ? rdy8 : rdy5)) nbusy++;
      if (w8 ? done8 : done5) ndone++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done5(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (done5) ok = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_val5 = 1'b0; in5 = '0; blz5 = 1'b0;
    in_val8 = 1'b0; in8 = '0; blz8 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rdy",  {31'd0, rdy5},  32'd1);
    check("rst_done", {31'd0, done5}, 32'd0);
    check("rst_ovf",  {31'd0, ovf5},  32'd0);
    check("rst_seg",  {18'd0, seg5},  {18'd0, S00});
    check("rst_seg8", {18'd0, seg8},  {18'd0, S00});
    rst_n = 1'b1;

    convert(1'b0, 8'd15, 1'b0, busy, dones);
    check("15_busy",  busy,  6);
    check("15_dones", dones, 1);
    check("15_seg",   {18'd0, seg5}, {18'd0, 7'b111_1001, 7'b001_0010});
    check("15_ovf",   {31'd0, ovf5}, 32'd0);

    convert(1'b0, 8'd7, 1'b1, busy, dones);
    check("7_blank",  {18'd0, seg5}, {18'd0, 7'b111_1111, 7'b111_1000});
    convert(1'b0, 8'd0, 1'b1, busy, dones);
    check("0_blank",  {18'd0, seg5}, {18'd0, 7'b111_1111, 7'b100_0000});
    convert(1'b0, 8'd20, 1'b1, busy, dones);
    check("20_blank", {18'd0, seg5}, {18'd0, 7'b010_0100, 7'b100_0000});

    convert(1'b1, 8'd99, 1'b0, busy, dones);
    check("99_busy",  busy, 9);
    check("99_seg",   {18'd0, seg8}, {18'd0, 7'b001_1000, 7'b001_1000});
    check("99_ovf",   {31'd0, ovf8}, 32'd0);
    convert(1'b1, 8'd100, 1'b0, busy, dones);
    check("100_ovf",  {31'd0, ovf8}, 32'd1);
    check("100_seg",  {18'd0, seg8}, {18'd0, 7'b011_1111, 7'b011_1111});
    convert(1'b1, 8'd255, 1'b1, busy, dones);
    check("255_ovf",  {31'd0, ovf8}, 32'd1);
    check("255_seg",  {18'd0, seg8}, {18'd0, 7'b011_1111, 7'b011_1111});
    convert(1'b1, 8'd5, 1'b1, busy, dones);
    check("5_ovf",    {31'd0, ovf8}, 32'd0);
    check("5_seg",    {18'd0, seg8}, {18'd0, 7'b111_1111, 7'b001_0010});

    // Busy input: 31 held valid while 12 converts
    @(negedge clk);
    in_val5 = 1'b1; in5 = 5'd12; blz5 = 1'b0;
    @(negedge clk);
    in5 = 5'd31;
    wait_done5(seen);
    check("12_done_seen", {31'd0, seen}, 32'd1);
    check("12_seg",  {18'd0, seg5}, {18'd0, 7'b111_1001, 7'b010_0100});
    check("12_rdy",  {31'd0, rdy5}, 32'd1);
    @(negedge clk);
    check("31_accepted", {31'd0, rdy5}, 32'd0);
    in_val5 = 1'b0;
    wait_done5(seen);
    check("31_done_seen", {31'd0, seen}, 32'd1);
    check("31_seg",  {18'd0, seg5}, {18'd0, 7'b011_0000, 7'b111_1001});

    // Reset in the middle of converting 29
    @(negedge clk);
    in_val5 = 1'b1; in5 = 5'd29; blz5 = 1'b0;
    @(negedge clk);
    in_val5 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_seg",  {18'd0, seg5}, {18'd0, S00});
    check("mid_rst_done", {31'd0, done5}, 32'd0);
    check("mid_rst_ovf",  {31'd0, ovf5}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rdy",  {31'd0, rdy5}, 32'd1);
    check("post_rst_done", {31'd0, done5}, 32'd0);
    convert(1'b0, 8'd29, 1'b0, busy, dones);
    check("29_dones", dones, 1);
    check("29_seg",   {18'd0, seg5}, {18'd0, 7'b010_0100, 7'b001_1000});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
